// File: rtl/rnd_sampler.sv
// Rejection sampler for the free-running random stream: returns one value in [0, RANGE).
// Out-of-range samples are retried up to MAX_TRIES times, then folded down into range.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for req; value/fallback hold the last result
// SAMPLE | examining rnd each cycle until accepted or the retry cap hits
module rnd_sampler #(
  parameter int RND_W     = 10,
  parameter int RANGE     = 600,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RND_W-1:0] rnd,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [RND_W-1:0] value,
  output logic             fallback
);

  if (RANGE < 2**(RND_W-1) || RANGE > 2**RND_W) begin : g_bad_range
    $error("rnd_sampler: RANGE must lie in [2**(RND_W-1), 2**RND_W]");
  end

  if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
    $error("rnd_sampler: MAX_TRIES must lie in [1, 255]");
  end

  // RANGE == 2**RND_W does not fit in RND_W bits; it truncates to 0 and every sample is accepted.
  localparam bit               FULL    = (RANGE == 2**RND_W);
  localparam logic [RND_W-1:0] RANGE_W = RND_W'(RANGE);
  localparam logic [7:0]       LAST    = 8'(MAX_TRIES - 1);

  typedef enum logic [0:0] {
    IDLE,
    SAMPLE
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       try_cnt, try_nxt;
  logic             busy_nxt, valid_nxt, fb_nxt;
  logic [RND_W-1:0] value_nxt;
  logic             in_range;
  logic [RND_W-1:0] fold;

  assign in_range = FULL || (rnd < RANGE_W);
  assign fold     = rnd - RANGE_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      try_cnt  <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      value    <= '0;
      fallback <= 1'b0;
    end else begin
      state    <= state_nxt;
      try_cnt  <= try_nxt;
      busy     <= busy_nxt;
      valid    <= valid_nxt;
      value    <= value_nxt;
      fallback <= fb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    try_nxt   = try_cnt;
    busy_nxt  = busy;
    valid_nxt = 1'b0;
    value_nxt = value;
    fb_nxt    = fallback;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SAMPLE;
          busy_nxt  = 1'b1;
          try_nxt   = '0;
        end
      end
      SAMPLE: begin
        if (in_range) begin
          value_nxt = rnd;
          fb_nxt    = 1'b0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (try_cnt != LAST) begin
          try_nxt = try_cnt + 8'd1;
        end else begin
          // rnd < 2**RND_W <= 2*RANGE, so the fold always lands below RANGE
          value_nxt = fold;
          fb_nxt    = 1'b1;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rnd_sampler.sv
// Self-checking bench for rnd_sampler (RND_W=10, RANGE=600, MAX_TRIES=8).
module tb_rnd_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [9:0] rnd = '0;
  logic       busy, valid, fallback;
  logic [9:0] value;

  rnd_sampler #(.RND_W(10), .RANGE(600), .MAX_TRIES(8)) dut (
    .clk(clk), .rst(rst), .rnd(rnd), .req(req),
    .busy(busy), .valid(valid), .value(value), .fallback(fallback)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] v;
    logic       fb;
  } exp_t;

  typedef struct {
    string      name;
    logic [9:0] r0, r1, r2;
    logic [9:0] ev;
    logic       efb;
    int         ebusy;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: outputs sampled on the falling edge.
  bit         prev_rst = 1'b1;
  logic [9:0] held_v   = '0;
  logic       held_fb  = 1'b0;
  exp_t       e;
  always @(negedge clk) begin
    if (prev_rst) begin
      check(busy == 0 && valid == 0 && value == 0 && fallback == 0, "reset_outputs",
            {busy, valid, fallback, value}, 0);
      sbq.delete();
      held_v  = '0;
      held_fb = 1'b0;
    end else if (valid) begin
      n_valid++;
      check(sbq.size() != 0, "valid_expected", n_valid, 0);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check(value == e.v, "value", value, e.v);
        check(fallback == e.fb, "fallback", fallback, e.fb);
      end
      held_v  = value;
      held_fb = fallback;
    end else begin
      check(value == held_v && fallback == held_fb, "value_held", value, held_v);
    end
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one request from IDLE and steps rnd through r0, r1, r2 (r2 repeated) per sample.
  task automatic run_vec(input vec_t v);
    logic [9:0] seq [3];
    int bc;
    seq = '{v.r0, v.r1, v.r2};
    bc  = 0;
    sbq.push_back('{v.ev, v.efb});
    req = 1'b1;
    rnd = v.r0;
    tick();
    req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      bc++;
      rnd = seq[(k > 2) ? 2 : k];
      tick();
    end
    check(bc == v.ebusy, {v.name, "_busy_cycles"}, bc, v.ebusy);
    check(valid == 1'b1, {v.name, "_valid"}, valid, 1);
    tick();
    check(valid == 1'b0, {v.name, "_valid_one_cycle"}, valid, 0);
  endtask

  initial begin
    vecs[0] = '{"accept123",   10'd123,  10'd123,  10'd123,  10'd123, 1'b0, 1};
    vecs[1] = '{"boundary",    10'd600,  10'd1023, 10'd599,  10'd599, 1'b0, 3};
    vecs[2] = '{"cap900",      10'd900,  10'd900,  10'd900,  10'd300, 1'b1, 8};
    vecs[3] = '{"zero",        10'd0,    10'd0,    10'd0,    10'd0,   1'b0, 1};
    vecs[4] = '{"cap1023",     10'd1023, 10'd1023, 10'd1023, 10'd423, 1'b1, 8};
    vecs[5] = '{"max_in",      10'd599,  10'd599,  10'd599,  10'd599, 1'b0, 1};
    vecs[6] = '{"rej_to_zero", 10'd600,  10'd600,  10'd0,    10'd0,   1'b0, 3};
    vecs[7] = '{"rej_to_one",  10'd1023, 10'd700,  10'd1,    10'd1,   1'b0, 3};

    // Reset then idle
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check(busy == 0 && valid == 0 && value == 0 && fallback == 0, "idle_after_reset",
            {busy, valid, fallback, value}, 0);
    end

    // Table of single requests
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // req pulsed while busy is ignored
    begin
      int nv0;
      nv0 = n_valid;
      sbq.push_back('{10'd7, 1'b0});
      req = 1'b1;
      rnd = 10'd1000;
      tick();
      req = 1'b0;
      tick();
      check(busy == 1'b1, "busy_during_retry", busy, 1);
      req = 1'b1;
      tick();
      req = 1'b0;
      rnd = 10'd7;
      tick();
      check(valid == 1'b1, "busy_req_valid", valid, 1);
      repeat (6) tick();
      check(n_valid - nv0 == 1, "busy_req_single_valid", n_valid - nv0, 1);
      check(sbq.size() == 0, "busy_req_sb_empty", sbq.size(), 0);
    end

    // req held high: back-to-back service, valid every 2 cycles
    repeat (4) sbq.push_back('{10'd5, 1'b0});
    req = 1'b1;
    rnd = 10'd5;
    for (int k = 0; k < 8; k++) begin
      tick();
      check(busy == (k % 2 == 0), "held_busy", busy, (k % 2 == 0));
      check(valid == (k % 2 == 1), "held_valid", valid, (k % 2 == 1));
    end
    req = 1'b0;
    repeat (4) tick();
    check(sbq.size() == 0, "held_sb_empty", sbq.size(), 0);

    // Reset mid-SAMPLE aborts without a valid pulse
    req = 1'b1;
    rnd = 10'd1000;
    tick();
    req = 1'b0;
    tick();
    tick();
    check(busy == 1'b1, "abort_busy_before_rst", busy, 1);
    rst = 1'b1;
    tick();
    check(busy == 0 && valid == 0 && value == 0 && fallback == 0, "abort_outputs",
          {busy, valid, fallback, value}, 0);
    rst = 1'b0;
    tick();
    run_vec('{"after_abort", 10'd42, 10'd42, 10'd42, 10'd42, 1'b0, 1});
    repeat (3) tick();
    check(sbq.size() == 0, "final_sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
